// File: rtl/counter_bank.sv
// Bank of NCH independent up/down counters with load, clear, snapshot and terminal-count pulses.
// Define COUNTER_BANK_SAT_EN to saturate at the boundary instead of wrapping.
module counter_bank #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         en,
  input  logic [NCH-1:0]         up_dn,
  input  logic [NCH-1:0]         clr,
  input  logic [NCH-1:0]         load,
  input  logic [NCH*WIDTH-1:0]   load_val,
  input  logic                   snap,
  output logic [NCH*WIDTH-1:0]   count,
  output logic [NCH*WIDTH-1:0]   snap_q,
  output logic [NCH-1:0]         tc,
  output logic                   any_tc
);

  logic [NCH*WIDTH-1:0] cnt_nxt;
  logic [NCH-1:0]       tc_nxt;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic             hit;

    assign cur = count[g*WIDTH +: WIDTH];

    always_comb begin
      nxt = cur;
      hit = 1'b0;
      if (clr[g]) begin
        nxt = '0;
      end else if (load[g]) begin
        nxt = load_val[g*WIDTH +: WIDTH];
      end else if (en[g]) begin
        if (up_dn[g]) begin
          hit = (cur == '1);
`ifdef COUNTER_BANK_SAT_EN
          nxt = hit ? cur : cur + 1'b1;
`else
          nxt = cur + 1'b1;
`endif
        end else begin
          hit = (cur == '0);
`ifdef COUNTER_BANK_SAT_EN
          nxt = hit ? cur : cur - 1'b1;
`else
          nxt = cur - 1'b1;
`endif
        end
      end
    end

    assign cnt_nxt[g*WIDTH +: WIDTH] = nxt;
    assign tc_nxt[g]                 = hit;
  end

  // snap_q captures the pre-update count, so it samples count rather than cnt_nxt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      snap_q <= '0;
      tc     <= '0;
      any_tc <= 1'b0;
    end else begin
      count  <= cnt_nxt;
      tc     <= tc_nxt;
      any_tc <= |tc_nxt;
      if (snap) snap_q <= count;
    end
  end

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent counter channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 16, bits per channel counter (2..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
REQ-005 SHALL have port en  input  NCH  per-channel count enable.
REQ-006 SHALL have port up_dn  input  NCH  per-channel direction; 1 = up, 0 = down.
REQ-007 SHALL have port clr  input  NCH  per-channel synchronous clear.
REQ-008 SHALL have port load  input  NCH  per-channel synchronous load.
REQ-009 SHALL have port load_val  input  NCH*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port snap  input  1  capture all channel counts simultaneously.
REQ-011 SHALL have port count  output  NCH*WIDTH  live registered counts, packed like load_val.
REQ-012 SHALL have port snap_q  output  NCH*WIDTH  captured counts, packed like load_val.
REQ-013 SHALL have port tc  output  NCH  registered per-channel terminal-count pulse.
REQ-014 SHALL have port any_tc  output  1  registered OR of the next-state tc vector, same cycle as tc.

Function
REQ-015 Per channel, per edge, priority SHALL be clr > load > en; clr sets count to 0, load sets count to load_val slice, en steps count by +1 (up) or -1 (down), otherwise hold.
REQ-016 Channels SHALL be fully independent; no channel's controls affect another's count or tc.
REQ-017 Counter update latency SHALL be one clock: the count output reflects the edge at which controls were sampled.
REQ-018 Boundary event SHALL be: en=1, clr=0, load=0, and (up_dn=1 with count=2^WIDTH-1) or (up_dn=0 with count=0).
REQ-019 tc[i] SHALL be 1 for exactly the one cycle following an edge at which channel i had a boundary event, else 0; clr or load in the same cycle suppresses tc.
REQ-020 Without saturation (see Configuration), a boundary event SHALL wrap: max+1 -> 0, 0-1 -> max.
REQ-021 snap=1 at an edge SHALL load snap_q with the count value of every channel present before that edge (pre-update value), all channels in the same cycle.
REQ-022 snap_q SHALL hold its value when snap=0; snap SHALL have no effect on count or tc.
REQ-023 Direction change with en=1 SHALL take effect on the same edge, with no idle cycle.

Reset
REQ-024 While reset=0, count, snap_q, tc and any_tc SHALL all be 0, independent of clk.
REQ-025 Reset asserted mid-count SHALL abort the channel's operation; the first edge after reset release SHALL evaluate controls normally from count=0.
REQ-026 Release of reset SHALL be assumed synchronous to clk by the integrator; the block SHALL contain no internal reset synchroniser.

Configuration
REQ-027 Macro COUNTER_BANK_SAT_EN SHALL select boundary behaviour at compile time.
REQ-028 With COUNTER_BANK_SAT_EN defined, a boundary event SHALL hold count at max (up) or 0 (down) instead of wrapping; tc SHALL still pulse for each such event, so a channel held at the boundary with en=1 asserts tc every cycle.
REQ-029 With COUNTER_BANK_SAT_EN undefined, wrap behaviour per REQ-020 SHALL apply; no saturation logic SHALL be present.

Verification (NCH=4, WIDTH=16)
REQ-030 Reset=0 mid-run with count0=0x1234 -> count, snap_q, tc and any_tc read 0 immediately; after release, en0=1 for 3 edges gives count0=3.
REQ-031 Load ch1 with 0xFFFE, then up-count 3 edges -> count1 = 0xFFFF, 0x0000, 0x0001 (wrap build); tc1=1 and any_tc=1 only in the 0x0000 cycle. In the SAT build: 0xFFFF held, tc1=1 on edges 2 and 3.
REQ-032 ch2 at 0, down-count 1 edge -> wrap build gives 0xFFFF with tc2 pulse; SAT build gives 0 with tc2 pulse.
REQ-033 ch3: clr=1, load=1 (load_val 0x00AA) and en=1 on the same edge -> count3=0, tc3=0; next edge with load only -> count3=0x00AA.
REQ-034 Counts {0x10,0x20,0x30,0x40} with all en=1 and snap=1 on one edge -> snap_q={0x10,0x20,0x30,0x40}, count={0x11,0x21,0x31,0x41}; snap_q is unchanged over 5 further edges.
